// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and constants for the data-RAM arbiter:
//               FSM state encodings, read-return owner tags, lock defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      ST_ARB    = 1'b0,
      ST_LOCK_D = 1'b1
   } arb_state_t;

   // Owner of a granted transaction
   typedef enum logic [0:0] {
      OWN_CORE = 1'b0,
      OWN_DBG  = 1'b1
   } owner_t;

   localparam int LOCK_MAX_DEFAULT = 64;
   // LOCK_MAX is bounded to 255, so an 8-bit counter always suffices
   localparam int LOCK_CNT_W       = 8;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of core, debug and RAM-side signals around the data
//               RAM arbiter. 'slave' is the arbiter's view, 'master' is the
//               view of the environment (core, debug port and RAM).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
   parameter int AW = 12
) ();
   import dmem_arbiter_pkg::*;

   // Core (MemoryAccess stage)
   logic [3:0]    c_rden;
   logic [3:0]    c_wren;
   logic [AW-1:0] c_addr;
   logic [31:0]   c_wrdata;
   logic          c_hold;
   logic          c_rvld;
   logic [31:0]   c_rddata;

   // Debug / loader port
   logic          d_req;
   logic [3:0]    d_we;
   logic          d_lock;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wrdata;
   logic          d_gnt;
   logic          d_rvld;
   logic [31:0]   d_rddata;

   // Single-port RAM
   logic          m_en;
   logic [3:0]    m_we;
   logic [AW-3:0] m_addr;
   logic [31:0]   m_wrdata;
   logic [31:0]   m_rddata;

   modport slave (
      input  c_rden, c_wren, c_addr, c_wrdata,
      output c_hold, c_rvld, c_rddata,
      input  d_req, d_we, d_lock, d_addr, d_wrdata,
      output d_gnt, d_rvld, d_rddata,
      output m_en, m_we, m_addr, m_wrdata,
      input  m_rddata
   );

   modport master (
      output c_rden, c_wren, c_addr, c_wrdata,
      input  c_hold, c_rvld, c_rddata,
      output d_req, d_we, d_lock, d_addr, d_wrdata,
      input  d_gnt, d_rvld, d_rddata,
      input  m_en, m_we, m_addr, m_wrdata,
      output m_rddata
   );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arb_lock_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dmem_arb_lock_timer
// Description : Counts consecutive debug-lock cycles. Loaded to 1 on the
//               locking grant, incremented on every locked cycle, cleared on
//               lock exit. expire flags that the lock reached LOCK_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_lock_timer
   import dmem_arbiter_pkg::*;
#(
   parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic load,
   input  wire logic inc,
   input  wire logic clr,
   output logic      expire
);

   logic [LOCK_CNT_W-1:0] r_lock_cnt;

   // Lock-cycle counter: clear beats load beats increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_cnt <= '0;
      end else if (clr) begin
         r_lock_cnt <= '0;
      end else if (load) begin
         r_lock_cnt <= LOCK_CNT_W'(1);
      end else if (inc) begin
         r_lock_cnt <= r_lock_cnt + LOCK_CNT_W'(1);
      end
   end

   assign expire = (r_lock_cnt >= LOCK_CNT_W'(LOCK_MAX));

endmodule : dmem_arb_lock_timer
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data RAM between the core and a
//               debug/loader port. One grant per cycle, 1-cycle read data
//               routed back to its owner, c_hold while the core is refused,
//               bounded debug lock with a forced core grant after timeout.
//               Optional: define DMEM_ARB_RR_EN for round-robin on
//               simultaneous requests (default: core has fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int AW       = 12,
   parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   dmem_arbiter_if.slave  bus
);

   arb_state_t r_state;
   logic       r_force_core;
   logic       r_tag_vld;
   owner_t     r_tag_own;

   logic w_c_req, w_c_wr, w_d_req, w_both, w_core_wins;
   logic w_c_gnt, w_d_gnt;
   logic w_lock_load, w_lock_inc, w_lock_clr, w_lock_expire;
   logic w_unused_addr_lsb;

   assign w_c_req = (|bus.c_rden) | (|bus.c_wren);
   assign w_c_wr  = |bus.c_wren;
   assign w_d_req = bus.d_req;
   assign w_both  = w_c_req & w_d_req;

   // Byte-lane address bits do not reach the word-addressed RAM
   assign w_unused_addr_lsb = ^{bus.c_addr[1:0], bus.d_addr[1:0]};

`ifdef DMEM_ARB_RR_EN
   owner_t r_last_owner;

   // Remember who was granted last so contention alternates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_owner <= OWN_CORE;
      end else if (w_c_gnt) begin
         r_last_owner <= OWN_CORE;
      end else if (w_d_gnt) begin
         r_last_owner <= OWN_DBG;
      end
   end

   assign w_core_wins = r_force_core | (r_last_owner == OWN_DBG);
`else
   assign w_core_wins = 1'b1;
`endif

   // Grant decision from current state and live requests
   always_comb begin
      w_c_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (r_state == ST_LOCK_D) begin
         w_d_gnt = w_d_req;
      end else begin
         w_c_gnt = w_c_req & (~w_d_req | w_core_wins);
         w_d_gnt = w_d_req & ~w_c_gnt;
      end
   end

   assign bus.c_hold = w_c_req & ~w_c_gnt;
   assign bus.d_gnt  = w_d_gnt;

   // RAM port follows the granted requester, idle-zero otherwise
   always_comb begin
      bus.m_en     = w_c_gnt | w_d_gnt;
      bus.m_we     = 4'b0000;
      bus.m_addr   = '0;
      bus.m_wrdata = '0;
      if (w_c_gnt) begin
         bus.m_we     = bus.c_wren;
         bus.m_addr   = bus.c_addr[AW-1:2];
         bus.m_wrdata = bus.c_wrdata;
      end else if (w_d_gnt) begin
         bus.m_we     = bus.d_we;
         bus.m_addr   = bus.d_addr[AW-1:2];
         bus.m_wrdata = bus.d_wrdata;
      end
   end

   assign w_lock_load = (r_state == ST_ARB) & w_d_gnt & bus.d_lock;
   assign w_lock_inc  = (r_state == ST_LOCK_D);
   assign w_lock_clr  = (r_state == ST_LOCK_D) & (~bus.d_lock | w_lock_expire);

   dmem_arb_lock_timer #(
      .LOCK_MAX (LOCK_MAX)
   ) u_lock_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (w_lock_load),
      .inc    (w_lock_inc),
      .clr    (w_lock_clr),
      .expire (w_lock_expire)
   );

   // Arbitration FSM: enter lock on a locking debug grant, leave on release
   // or timeout; a timeout owes the core the next contested slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_ARB;
         r_force_core <= 1'b0;
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_d_gnt && bus.d_lock) begin
                  r_state <= ST_LOCK_D;
               end
               if (r_force_core && w_c_gnt && w_both) begin
                  r_force_core <= 1'b0;
               end
            end
            ST_LOCK_D: begin
               if (!bus.d_lock || w_lock_expire) begin
                  r_state <= ST_ARB;
               end
               if (w_lock_expire) begin
                  r_force_core <= 1'b1;
               end
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

   // Read-return tag: who gets m_rddata next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_vld <= 1'b0;
         r_tag_own <= OWN_CORE;
      end else begin
         r_tag_vld <= (w_c_gnt & ~w_c_wr) | (w_d_gnt & ~(|bus.d_we));
         r_tag_own <= w_c_gnt ? OWN_CORE : OWN_DBG;
      end
   end

   assign bus.c_rvld   = r_tag_vld & (r_tag_own == OWN_CORE);
   assign bus.d_rvld   = r_tag_vld & (r_tag_own == OWN_DBG);
   assign bus.c_rddata = bus.c_rvld ? bus.m_rddata : 32'h0;
   assign bus.d_rddata = bus.d_rvld ? bus.m_rddata : 32'h0;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a small
//               behavioural RAM model (LOCK_MAX = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW       = 12;
   localparam int LOCK_MAX = 4;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] mem [0:1023];

   dmem_arbiter_if #(.AW(AW)) bus ();

   dmem_arbiter #(
      .AW       (AW),
      .LOCK_MAX (LOCK_MAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // RAM model: preload during reset, 1-cycle read, byte-enabled write
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
         mem[0] <= 32'h1111_1111;
         mem[1] <= 32'h2222_2222;
         mem[4] <= 32'hDEAD_BEEF;
         bus.m_rddata <= 32'h0;
      end else if (bus.m_en) begin
         if (bus.m_we == 4'b0000) begin
            bus.m_rddata <= mem[bus.m_addr];
         end else begin
            for (int b = 0; b < 4; b++)
               if (bus.m_we[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wrdata[8*b +: 8];
         end
      end
   end

   task automatic idle_inputs();
      bus.c_rden = 4'h0; bus.c_wren = 4'h0; bus.c_addr = '0; bus.c_wrdata = '0;
      bus.d_req = 1'b0; bus.d_we = 4'h0; bus.d_lock = 1'b0; bus.d_addr = '0; bus.d_wrdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.m_en, bus.m_we, bus.c_hold, bus.d_gnt, bus.c_rvld, bus.d_rvld} !== 9'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bus.m_en, bus.m_we, bus.c_hold, bus.d_gnt, bus.c_rvld, bus.d_rvld});
      end
      n_checks++;
      if ({bus.m_addr, bus.m_wrdata, bus.c_rddata, bus.d_rddata} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h want 0", {bus.m_addr, bus.m_wrdata, bus.c_rddata, bus.d_rddata});
      end
      n_checks++;
      if (dut.r_state !== ST_ARB) begin
         n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, ST_ARB);
      end
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_core_read();
      bus.c_rden = 4'hF; bus.c_addr = 12'h010;
      @(negedge clk);
      n_checks++;
      if ({bus.m_en, bus.m_we, bus.m_addr, bus.c_hold} !== {1'b1, 4'h0, 10'h004, 1'b0}) begin
         n_fail++; $display("FAIL core_rd_issue: got en=%b we=%h addr=%h hold=%b want en=1 we=0 addr=004 hold=0",
                            bus.m_en, bus.m_we, bus.m_addr, bus.c_hold);
      end
      next_cycle(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({bus.c_rvld, bus.c_rddata, bus.d_rvld, bus.d_rddata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
         n_fail++; $display("FAIL core_rd_return: got c_rvld=%b c_rd=%h d_rvld=%b d_rd=%h want 1 deadbeef 0 0",
                            bus.c_rvld, bus.c_rddata, bus.d_rvld, bus.d_rddata);
      end
      next_cycle();
   endtask

   task automatic test_contend();
      // Debug-only read first, so both arbitration modes favour the core next
      bus.d_req = 1'b1; bus.d_addr = 12'h004;
      @(negedge clk);
      n_checks++;
      if ({bus.d_gnt, bus.c_hold} !== 2'b10) begin
         n_fail++; $display("FAIL dbg_solo_gnt: got %b want 10", {bus.d_gnt, bus.c_hold});
      end
      next_cycle();
      bus.c_wren = 4'b0011; bus.c_addr = 12'h020; bus.c_wrdata = 32'h0000_CAFE;
      @(negedge clk);
      n_checks++;
      if ({bus.c_hold, bus.d_gnt} !== 2'b00) begin
         n_fail++; $display("FAIL contend_core_wins: got hold,gnt=%b want 00", {bus.c_hold, bus.d_gnt});
      end
      n_checks++;
      if ({bus.m_we, bus.m_addr, bus.m_wrdata} !== {4'b0011, 10'h008, 32'h0000CAFE}) begin
         n_fail++; $display("FAIL contend_ram_wr: got we=%b addr=%h wd=%h want 0011 008 0000cafe",
                            bus.m_we, bus.m_addr, bus.m_wrdata);
      end
      n_checks++;
      if ({bus.d_rvld, bus.d_rddata} !== {1'b1, 32'h22222222}) begin
         n_fail++; $display("FAIL dbg_solo_ret: got %b %h want 1 22222222", bus.d_rvld, bus.d_rddata);
      end
      next_cycle();
      bus.c_wren = 4'h0; bus.c_wrdata = '0;
      @(negedge clk);
      n_checks++;
      if ({bus.d_gnt, bus.m_we, bus.m_addr, bus.c_rvld, bus.d_rvld} !== {1'b1, 4'h0, 10'h001, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL contend_dbg_next: got gnt=%b we=%h addr=%h c_rvld=%b d_rvld=%b want 1 0 001 0 0",
                            bus.d_gnt, bus.m_we, bus.m_addr, bus.c_rvld, bus.d_rvld);
      end
      next_cycle();
      bus.d_req = 1'b0; bus.c_rden = 4'hF; bus.c_addr = 12'h020;
      @(negedge clk);
      n_checks++;
      if ({bus.d_rvld, bus.d_rddata, bus.c_rddata} !== {1'b1, 32'h22222222, 32'h0}) begin
         n_fail++; $display("FAIL contend_dbg_ret: got %b %h c_rd=%h want 1 22222222 0", bus.d_rvld, bus.d_rddata, bus.c_rddata);
      end
      next_cycle(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({bus.c_rvld, bus.c_rddata} !== {1'b1, 32'hA500CAFE}) begin
         n_fail++; $display("FAIL byte_write_readback: got %b %h want 1 a500cafe", bus.c_rvld, bus.c_rddata);
      end
      next_cycle();
   endtask

   task automatic test_lock_timeout();
      bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 12'h004;
      @(negedge clk);
      n_checks++;
      if ({bus.d_gnt, bus.c_hold} !== 2'b10) begin
         n_fail++; $display("FAIL lock_grant: got %b want 10", {bus.d_gnt, bus.c_hold});
      end
      next_cycle();
      bus.c_rden = 4'hF; bus.c_addr = 12'h000;
      for (int i = 0; i < LOCK_MAX; i++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.c_hold, bus.d_gnt} !== 2'b11) begin
            n_fail++; $display("FAIL lock_hold[%0d]: got hold,gnt=%b want 11", i, {bus.c_hold, bus.d_gnt});
         end
         n_checks++;
         if ({bus.d_rvld, bus.d_rddata, bus.c_rvld} !== {1'b1, 32'h22222222, 1'b0}) begin
            n_fail++; $display("FAIL lock_ret[%0d]: got d_rvld=%b d_rd=%h c_rvld=%b want 1 22222222 0",
                               i, bus.d_rvld, bus.d_rddata, bus.c_rvld);
         end
         next_cycle();
      end
      @(negedge clk);
      n_checks++;
      if ({bus.c_hold, bus.d_gnt, bus.m_en, bus.m_addr} !== {1'b0, 1'b0, 1'b1, 10'h000}) begin
         n_fail++; $display("FAIL forced_core: got hold=%b gnt=%b en=%b addr=%h want 0 0 1 000",
                            bus.c_hold, bus.d_gnt, bus.m_en, bus.m_addr);
      end
      n_checks++;
      if (dut.r_state !== ST_ARB) begin
         n_fail++; $display("FAIL lock_exit_state: got %0d want %0d", dut.r_state, ST_ARB);
      end
      next_cycle(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({bus.c_rvld, bus.c_rddata, bus.d_rvld} !== {1'b1, 32'h11111111, 1'b0}) begin
         n_fail++; $display("FAIL forced_core_ret: got %b %h d_rvld=%b want 1 11111111 0", bus.c_rvld, bus.c_rddata, bus.d_rvld);
      end
      next_cycle();
   endtask

   task automatic test_lock_release();
      bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_we = 4'hF; bus.d_addr = 12'h040; bus.d_wrdata = 32'h1234_5678;
      @(negedge clk);
      n_checks++;
      if ({bus.d_gnt, bus.m_we} !== {1'b1, 4'hF}) begin
         n_fail++; $display("FAIL release_wr_gnt: got %b %h want 1 f", bus.d_gnt, bus.m_we);
      end
      next_cycle();
      bus.d_lock = 1'b0; bus.d_we = 4'h0; bus.d_wrdata = '0;
      bus.c_rden = 4'hF; bus.c_addr = 12'h000;
      @(negedge clk);
      n_checks++;
      if ({bus.d_gnt, bus.c_hold} !== 2'b11) begin
         n_fail++; $display("FAIL release_last_dbg: got gnt,hold=%b want 11", {bus.d_gnt, bus.c_hold});
      end
      next_cycle();
      bus.d_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.c_hold, bus.m_en, bus.m_addr} !== {1'b0, 1'b1, 10'h000}) begin
         n_fail++; $display("FAIL release_core_gnt: got hold=%b en=%b addr=%h want 0 1 000", bus.c_hold, bus.m_en, bus.m_addr);
      end
      n_checks++;
      if ({bus.d_rvld, bus.d_rddata} !== {1'b1, 32'h12345678}) begin
         n_fail++; $display("FAIL release_dbg_ret: got %b %h want 1 12345678", bus.d_rvld, bus.d_rddata);
      end
      next_cycle(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({bus.c_rvld, bus.c_rddata} !== {1'b1, 32'h11111111}) begin
         n_fail++; $display("FAIL release_core_ret: got %b %h want 1 11111111", bus.c_rvld, bus.c_rddata);
      end
      next_cycle();
   endtask

   task automatic test_contended_stream();
      logic exp_c;
      logic prev_c;
      bus.d_req = 1'b1; bus.d_addr = 12'h004;
      @(negedge clk);
      n_checks++;
      if (bus.d_gnt !== 1'b1) begin
         n_fail++; $display("FAIL stream_prime: got %b want 1", bus.d_gnt);
      end
      next_cycle();
      bus.c_rden = 4'hF; bus.c_addr = 12'h000;
      prev_c = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_c = RR ? (i % 2 == 0) : 1'b1;
         @(negedge clk);
         n_checks++;
         if ({bus.c_hold, bus.d_gnt} !== {!exp_c, !exp_c}) begin
            n_fail++; $display("FAIL stream_gnt[%0d]: got hold,gnt=%b want %b", i, {bus.c_hold, bus.d_gnt}, {!exp_c, !exp_c});
         end
         n_checks++;
         if ({bus.c_rvld, bus.d_rvld, bus.c_rddata, bus.d_rddata} !==
             {prev_c, !prev_c, (prev_c ? {32'h11111111, 32'h0} : {32'h0, 32'h22222222})}) begin
            n_fail++; $display("FAIL stream_ret[%0d]: got c=%b/%h d=%b/%h want core_owner=%b",
                               i, bus.c_rvld, bus.c_rddata, bus.d_rvld, bus.d_rddata, prev_c);
         end
         prev_c = exp_c;
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({bus.c_rvld, bus.d_rvld} !== {prev_c, !prev_c}) begin
         n_fail++; $display("FAIL stream_tail: got %b want %b", {bus.c_rvld, bus.d_rvld}, {prev_c, !prev_c});
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic prev_core;
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         if (i % 2 == 0) begin
            bus.c_rden = 4'hF; bus.c_addr = 12'h000;
         end else begin
            bus.d_req = 1'b1; bus.d_addr = 12'h004;
         end
         @(negedge clk);
         n_checks++;
         if ({bus.m_en, bus.m_addr} !== {1'b1, (i % 2 == 0) ? 10'h000 : 10'h001}) begin
            n_fail++; $display("FAIL b2b_issue[%0d]: got en=%b addr=%h", i, bus.m_en, bus.m_addr);
         end
         if (i > 0) begin
            n_checks++;
            if ({bus.c_rvld, bus.d_rvld, bus.c_rddata, bus.d_rddata} !==
                {prev_core, !prev_core, (prev_core ? {32'h11111111, 32'h0} : {32'h0, 32'h22222222})}) begin
               n_fail++; $display("FAIL b2b_ret[%0d]: got c=%b/%h d=%b/%h want core_owner=%b",
                                  i, bus.c_rvld, bus.c_rddata, bus.d_rvld, bus.d_rddata, prev_core);
            end
         end
         prev_core = (i % 2 == 0);
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({bus.d_rvld, bus.d_rddata, bus.c_rvld} !== {1'b1, 32'h22222222, 1'b0}) begin
         n_fail++; $display("FAIL b2b_tail: got %b %h c_rvld=%b want 1 22222222 0", bus.d_rvld, bus.d_rddata, bus.c_rvld);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_lock();
      bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 12'h004;
      @(negedge clk);
      n_checks++;
      if (bus.d_gnt !== 1'b1) begin
         n_fail++; $display("FAIL rml_grant: got %b want 1", bus.d_gnt);
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (dut.r_state !== ST_LOCK_D) begin
         n_fail++; $display("FAIL rml_in_lock: got %0d want %0d", dut.r_state, ST_LOCK_D);
      end
      @(posedge clk); #2;
      n_checks++;
      if (bus.d_rvld !== 1'b1) begin
         n_fail++; $display("FAIL rml_pending: got %b want 1", bus.d_rvld);
      end
      rst_n = 1'b0;
      idle_inputs();
      #1;
      n_checks++;
      if ({bus.d_rvld, bus.d_gnt, bus.d_rddata} !== {1'b0, 1'b0, 32'h0}) begin
         n_fail++; $display("FAIL rml_drop: got rvld=%b gnt=%b rd=%h want 0 0 0", bus.d_rvld, bus.d_gnt, bus.d_rddata);
      end
      n_checks++;
      if (dut.r_state !== ST_ARB) begin
         n_fail++; $display("FAIL rml_state: got %0d want %0d", dut.r_state, ST_ARB);
      end
      next_cycle();
      rst_n = 1'b1;
      bus.c_rden = 4'hF; bus.c_addr = 12'h010;
      @(negedge clk);
      n_checks++;
      if ({bus.c_hold, bus.m_en, bus.m_addr} !== {1'b0, 1'b1, 10'h004}) begin
         n_fail++; $display("FAIL rml_core_gnt: got hold=%b en=%b addr=%h want 0 1 004", bus.c_hold, bus.m_en, bus.m_addr);
      end
      next_cycle(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({bus.c_rvld, bus.c_rddata} !== {1'b1, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL rml_core_ret: got %b %h want 1 deadbeef", bus.c_rvld, bus.c_rddata);
      end
      next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_core_read();
      test_contend();
      test_lock_timeout();
      test_lock_release();
      test_contended_stream();
      test_back_to_back();
      test_reset_mid_lock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data RAM between the core's MemoryAccess stage and a debug/loader port. Grants one transaction per cycle and routes the 1-cycle-latency read data back to its owner. Raises a hold to the core whenever the core's access is refused. Supports a debug lock with a bounded lock time, so the core cannot be starved indefinitely.

## Interface
- AW, 12: byte address width; word address is AW-2 bits.
- LOCK_MAX, 64: maximum consecutive cycles debug may own the RAM under lock; range 1..255.

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- c_rden  in  4  core byte read enables; read when non-zero
- c_wren  in  4  core byte write enables; write when non-zero; takes precedence over c_rden
- c_addr  in  AW  core byte address
- c_wrdata  in  32  core write data
- c_hold  out  1  core request present and not granted this cycle
- c_rvld  out  1  core read data valid
- c_rddata  out  32  core read data
- d_req  in  1  debug request
- d_we  in  4  debug byte write enables; 0 means read
- d_lock  in  1  keep ownership after grant
- d_addr  in  AW  debug byte address
- d_wrdata  in  32  debug write data
- d_gnt  out  1  debug request accepted this cycle
- d_rvld  out  1  debug read data valid
- d_rddata  out  32  debug read data
- m_en  out  1  RAM access strobe
- m_we  out  4  RAM byte write enables
- m_addr  out  AW-2  RAM word address, taken from addr[AW-1:2]
- m_wrdata  out  32  RAM write data
- m_rddata  in  32  RAM read data, valid the cycle after m_en with m_we==0

## Operation
- Core request: c_req = |c_rden | |c_wren. Debug request: d_req.
- Request handshake: the requester holds address and data stable until it is granted.
  - Core is granted when c_req & ~c_hold.
  - Debug is granted when d_gnt.
- Grants and c_hold are combinational from the current state and requests. RAM port signals are a combinational mux of the granted requester.
- FSM has two states: ARB and LOCK_D.
- ARB state:
  - Only one side requests: that side is granted.
  - Both sides request: core wins (see Configuration).
  - Debug granted with d_lock=1: go to LOCK_D and load lock_cnt=1.
- LOCK_D state:
  - Debug is always granted when d_req is high. Core is held, even if debug is idle.
  - lock_cnt increments on every LOCK_D cycle.
  - Exit to ARB when d_lock=0, or when lock_cnt reaches LOCK_MAX.
  - On a LOCK_MAX exit, set force_core. While force_core is set, the next arbitration with both sides requesting goes to the core. force_core clears on that core grant.
- Read return:
  - A registered tag {vld, owner} is captured on each granted read.
  - The next cycle, the tagged owner sees rvld=1 and its rddata = m_rddata. The other side's rddata is 0.
  - Writes produce no rvld.
- No outstanding-transaction limit exists beyond the single tag stage. Back-to-back reads from alternating owners are legal.

## Timing
- Reset values:
  - FSM = ARB; lock_cnt=0; force_core=0; last_owner=core; tag invalid.
  - All outputs are 0 while there are no requests.
- Read latency is 1 cycle from grant to rvld. Write completes at the grant edge.
- c_hold is asserted in the same cycle the conflict exists. The core stalls with its signals stable and is granted in a later cycle.
- Reset mid-lock: FSM returns to ARB immediately and any pending rvld is dropped (asynchronous).
- d_lock falling in the same cycle as a debug grant: that grant completes, and the FSM returns to ARB on the next edge.
- LOCK_MAX=1: lock lasts one cycle beyond the initial grant.

## Configuration
- DMEM_ARB_RR_EN defined:
  - Simultaneous requests in ARB go round-robin, to the side opposite last_owner.
  - last_owner updates on every grant.
  - force_core still overrides round-robin.
- Undefined: fixed priority, core first; last_owner register is not built.

## Structure
- Shared package/defines file holds:
  - state encodings ST_ARB, ST_LOCK_D;
  - owner tags OWN_CORE=0, OWN_DBG=1;
  - default LOCK_MAX.
- One sub-module, dmem_arb_lock_timer: the lock_cnt counter with load/inc/expire flag. Everything else stays in dmem_arbiter.

## Test plan
- Core read at addr 0x010 with RAM preloaded 0xDEADBEEF, no debug traffic -> m_en=1, m_addr=0x004; next cycle c_rvld=1, c_rddata=0xDEADBEEF; c_hold stays 0.
- Core write c_wren=4'b0011 and debug read issued in the same cycle -> core granted, c_hold=0, d_gnt=0; debug granted next cycle, d_rvld the cycle after.
- Debug lock with d_lock held high, LOCK_MAX=4, core requesting continuously -> c_hold=1 for exactly the lock span; forced exit; the next contested cycle grants the core.
- DMEM_ARB_RR_EN defined, both sides requesting reads every cycle for 6 cycles -> grants alternate C,D,C,D,C,D; rvld owners follow one cycle later.
- Alternating reads core@0x000 then debug@0x004 back-to-back -> c_rvld and d_rvld each carry the correct word; no cross-routing.
- rst asserted while in LOCK_D with a pending debug read -> d_rvld=0, d_gnt=0, FSM=ARB immediately; after release, core is granted on first request.
